mem_port_arbiter: RTL

- Shares the single-port 32-word data memory between two requesters:
  - Requester 0: the block-accumulation sequencer.
  - Requester 1: the host/loader that preloads operands and reads back sums.
- Serialises transactions with round-robin fairness.
- Drives the memory ReadEnable/WriteEnable/Address strobes, including multi-cycle read-latency hold.
- Returns read data and a one-cycle Ack to the owner.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_if.sv | 32 +++
 rtl/mem_port_arbiter_rr_select2.sv | 16 +
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and encodings for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int MEM_DEPTH = 32;
    localparam int ADDR_W    = 5;
    localparam int DATA_W    = 8;

    // Requester IDs; the ID doubles as the priority-pointer / owner value.
    localparam logic REQ_SEQ  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        ACK    = 2'b10
    } state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus memory strobes, grouped as one bus.
interface mem_port_arbiter_if;
    import mem_port_arbiter_pkg::*;

    logic              Req0, Req1;
    logic              Wr0, Wr1;
    logic [ADDR_W-1:0] Addr0, Addr1;
    logic [DATA_W-1:0] WData0, WData1;
    logic              Gnt0, Gnt1;
    logic              Ack0, Ack1;
    logic [DATA_W-1:0] RData;
    logic              ReadEnable, WriteEnable;
    logic [ADDR_W-1:0] Address;
    logic [DATA_W-1:0] MemWData;
    logic [DATA_W-1:0] MemRData;
    logic              Busy;

    // Arbiter side
    modport slave (
        input  Req0, Req1, Wr0, Wr1, Addr0, Addr1, WData0, WData1, MemRData,
        output Gnt0, Gnt1, Ack0, Ack1, RData, ReadEnable, WriteEnable,
               Address, MemWData, Busy
    );

    // Requesters + memory side
    modport master (
        output Req0, Req1, Wr0, Wr1, Addr0, Addr1, WData0, WData1, MemRData,
        input  Gnt0, Gnt1, Ack0, Ack1, RData, ReadEnable, WriteEnable,
               Address, MemWData, Busy
    );

endinterface

// File: rtl/mem_port_arbiter_rr_select2.sv
// Two-way round-robin pick: a lone request wins, a tie goes to the pointer.
module rr_select2 (
    input  logic req0,
    input  logic req1,
    input  logic ptr,
    output logic valid,
    output logic winner
);

    // Pure combinational selection
    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? ptr : req1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises two requesters onto a single-port memory with round-robin
// fairness; reads hold ReadEnable/Address for READ_LAT cycles.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int READ_LAT = 2   // 1..7
) (
    input  logic                Clock,
    input  logic                Reset,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [2:0] LAST_CNT = 3'(READ_LAT - 1);

    state_e            state_q, state_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic              ptr_q, ptr_d;

    logic sel_valid, sel_winner;

    rr_select2 u_sel (
        .req0   (bus.Req0),
        .req1   (bus.Req1),
        .ptr    (ptr_q),
        .valid  (sel_valid),
        .winner (sel_winner)
    );

    // Next-state: grant latch in IDLE, latency count in ACCESS, pointer flip in ACK
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    owner_d = sel_winner;
                    wr_d    = sel_winner ? bus.Wr1   : bus.Wr0;
                    addr_d  = sel_winner ? bus.Addr1 : bus.Addr0;
                    // MemWData keeps the last write's data across reads
                    if (sel_winner ? bus.Wr1 : bus.Wr0)
                        wdata_d = sel_winner ? bus.WData1 : bus.WData0;
                    cnt_d   = 3'd0;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (wr_q) begin
                    state_d = ACK;
                end else if (cnt_q == LAST_CNT) begin
                    rdata_d = bus.MemRData;
                    cnt_d   = 3'd0;
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            ACK: begin
                ptr_d   = ~owner_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, synchronous reset abandons any transaction
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            owner_q <= REQ_SEQ;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= 3'd0;
            ptr_q   <= REQ_SEQ;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        bus.ReadEnable  = (state_q == ACCESS) && !wr_q;
        bus.WriteEnable = (state_q == ACCESS) &&  wr_q;
        bus.Address     = addr_q;
        bus.MemWData    = wdata_q;
        bus.RData       = rdata_q;
        bus.Busy        = (state_q != IDLE);
        bus.Gnt0        = (state_q != IDLE) && (owner_q == REQ_SEQ);
        bus.Gnt1        = (state_q != IDLE) && (owner_q == REQ_HOST);
        bus.Ack0        = (state_q == ACK)  && (owner_q == REQ_SEQ);
        bus.Ack1        = (state_q == ACK)  && (owner_q == REQ_HOST);
    end

endmodule
